// File: rtl/cga_pkg.sv
// Shared types for the CGA video RAM scheduler: return-path owner tags,
// grant FSM states and default bus widths.
package cga_pkg;

   localparam int CGA_AW = 14;
   localparam int CGA_DW = 8;

   typedef enum logic [1:0] {
      TAG_NONE = 2'd0,
      TAG_CHAR = 2'd1,
      TAG_ATT  = 2'd2,
      TAG_CPU  = 2'd3
   } tag_e;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_FETCH_CHAR = 2'd1,
      ST_FETCH_ATT  = 2'd2
   } state_e;

endpackage

// File: rtl/cga_vram_retpipe.sv
// Return path: remembers who owned last cycle's VRAM slot and steers the
// read data that arrives one cycle later to that owner.
module cga_vram_retpipe
   import cga_pkg::*;
#(
   parameter int DW = CGA_DW
) (
   input  logic          clk,
   input  logic          reset_n,
   input  tag_e          i_tag,
   input  logic          i_cpu_we,
   input  logic          i_done_ok,
   input  logic [DW-1:0] i_ram_rdata,
   output logic          o_cpu_ack,
   output logic [DW-1:0] o_cpu_rdata,
   output logic [DW-1:0] o_char_byte,
   output logic [DW-1:0] o_att_byte,
   output logic          o_fetch_done
);

   tag_e          r_tag;
   logic          r_tag_we;
   logic          r_done_ok;
   logic          r_fetch_done;
   logic [DW-1:0] r_cpu_rdata;
   logic [DW-1:0] r_char_byte;
   logic [DW-1:0] r_att_byte;
   logic          w_cpu_rd;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_tag        <= TAG_NONE;
         r_tag_we     <= 1'b0;
         r_done_ok    <= 1'b0;
         r_fetch_done <= 1'b0;
         r_cpu_rdata  <= '0;
         r_char_byte  <= '0;
         r_att_byte   <= '0;
      end else begin
         r_tag        <= i_tag;
         r_tag_we     <= i_cpu_we;
         r_done_ok    <= i_done_ok;
         r_fetch_done <= (r_tag == TAG_ATT) && r_done_ok;
         case (r_tag)
            TAG_CHAR: r_char_byte <= i_ram_rdata;
            TAG_ATT:  r_att_byte  <= i_ram_rdata;
            TAG_CPU:  if (!r_tag_we) r_cpu_rdata <= i_ram_rdata;
            default:  ;
         endcase
      end
   end

   // CPU read data must be valid in the ack cycle itself, so bypass the
   // holding register while the returning byte is on ram_rdata.
   assign w_cpu_rd     = (r_tag == TAG_CPU) && !r_tag_we;
   assign o_cpu_ack    = (r_tag == TAG_CPU);
   assign o_cpu_rdata  = w_cpu_rd ? i_ram_rdata : r_cpu_rdata;
   assign o_char_byte  = r_char_byte;
   assign o_att_byte   = r_att_byte;
   assign o_fetch_done = r_fetch_done;

endmodule

// File: rtl/cga_vram_sched.sv
// Per-cycle owner arbitration of the single-port CGA VRAM between the
// display fetch pair (absolute priority) and the CPU bus interface.
//
// state         | meaning
// ST_IDLE       | slot free; CPU may be granted
// ST_FETCH_CHAR | slot owned by display, character byte {addr,0}
// ST_FETCH_ATT  | slot owned by display, attribute byte {addr,1}
module cga_vram_sched
   import cga_pkg::*;
#(
   parameter int AW = CGA_AW,
   parameter int DW = CGA_DW
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          char_tick,
   input  logic          display_enable,
   input  logic [AW-2:0] crtc_addr,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_ack,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_wait,
   output logic [AW-1:0] ram_addr,
   output logic          ram_we,
   output logic [DW-1:0] ram_wdata,
   input  logic [DW-1:0] ram_rdata,
   output logic [DW-1:0] char_byte,
   output logic [DW-1:0] att_byte,
   output logic          fetch_done,
   output logic          overrun
);

   state_e        r_state;
   state_e        w_state_nxt;
   logic [AW-2:0] r_crtc_addr;
   logic          r_live;
   logic          r_overrun;
   tag_e          w_tag;
   logic          w_tag_we;
   logic          w_done_ok;
   logic          w_fetch_req;
   logic          w_cpu_gnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ST_IDLE;
         r_crtc_addr <= '0;
         r_live      <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_live      <= 1'b1;
         r_overrun   <= char_tick && (r_state != ST_IDLE);
         if (char_tick) r_crtc_addr <= crtc_addr;
      end
   end

   assign w_fetch_req = char_tick && display_enable;

   // An ack this cycle means a grant last cycle, which enforces the
   // one-access-per-two-cycles CPU spacing. r_live keeps the bus quiet
   // while in reset and for the first clock after release.
   assign w_cpu_gnt = r_live && (r_state == ST_IDLE) && !char_tick &&
                      cpu_req && !cpu_ack;

   always_comb begin
      w_state_nxt = r_state;
      w_tag       = TAG_NONE;
      w_tag_we    = 1'b0;
      w_done_ok   = 1'b0;
      ram_addr    = '0;
      ram_we      = 1'b0;
      ram_wdata   = '0;
      case (r_state)
         ST_IDLE: begin
            if (w_fetch_req) w_state_nxt = ST_FETCH_CHAR;
            if (w_cpu_gnt) begin
               ram_addr  = cpu_addr;
               ram_we    = cpu_we;
               ram_wdata = cpu_wdata;
               w_tag     = TAG_CPU;
               w_tag_we  = cpu_we;
            end
         end
         ST_FETCH_CHAR: begin
            ram_addr = {r_crtc_addr, 1'b0};
            w_tag    = TAG_CHAR;
            if (char_tick) w_state_nxt = display_enable ? ST_FETCH_CHAR : ST_IDLE;
            else           w_state_nxt = ST_FETCH_ATT;
         end
         ST_FETCH_ATT: begin
            ram_addr    = {r_crtc_addr, 1'b1};
            w_tag       = TAG_ATT;
            // A tick here aborts the pair: the byte still lands, no done.
            w_done_ok   = !char_tick;
            w_state_nxt = w_fetch_req ? ST_FETCH_CHAR : ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   cga_vram_retpipe #(
      .DW (DW)
   ) u_retpipe (
      .clk          (clk),
      .reset_n      (reset_n),
      .i_tag        (w_tag),
      .i_cpu_we     (w_tag_we),
      .i_done_ok    (w_done_ok),
      .i_ram_rdata  (ram_rdata),
      .o_cpu_ack    (cpu_ack),
      .o_cpu_rdata  (cpu_rdata),
      .o_char_byte  (char_byte),
      .o_att_byte   (att_byte),
      .o_fetch_done (fetch_done)
   );

   assign cpu_wait = cpu_req && !cpu_ack;
   assign overrun  = r_overrun;

endmodule

// File: tb/tb_cga_vram_sched.sv
// Directed bench for cga_vram_sched with a write-first 1-cycle VRAM model.
module tb_cga_vram_sched;

   logic        clk;
   logic        reset_n;
   logic        char_tick;
   logic        display_enable;
   logic [12:0] crtc_addr;
   logic        cpu_req;
   logic        cpu_we;
   logic [13:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_ack;
   logic [7:0]  cpu_rdata;
   logic        cpu_wait;
   logic [13:0] ram_addr;
   logic        ram_we;
   logic [7:0]  ram_wdata;
   logic [7:0]  ram_rdata;
   logic [7:0]  char_byte;
   logic [7:0]  att_byte;
   logic        fetch_done;
   logic        overrun;

   logic [7:0]  mem [0:16383];
   int          checks;
   int          errors;

   cga_vram_sched dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .char_tick      (char_tick),
      .display_enable (display_enable),
      .crtc_addr      (crtc_addr),
      .cpu_req        (cpu_req),
      .cpu_we         (cpu_we),
      .cpu_addr       (cpu_addr),
      .cpu_wdata      (cpu_wdata),
      .cpu_ack        (cpu_ack),
      .cpu_rdata      (cpu_rdata),
      .cpu_wait       (cpu_wait),
      .ram_addr       (ram_addr),
      .ram_we         (ram_we),
      .ram_wdata      (ram_wdata),
      .ram_rdata      (ram_rdata),
      .char_byte      (char_byte),
      .att_byte       (att_byte),
      .fetch_done     (fetch_done),
      .overrun        (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= ram_we ? ram_wdata : mem[ram_addr];
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Full CPU transaction; returns at the negedge of the ack cycle.
   task automatic cpu_xfer(input logic we, input logic [13:0] a, input logic [7:0] d);
      logic ok;
      ok = 1'b0;
      cyc();
      cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
      for (int k = 0; k < 8 && !ok; k++) begin
         @(negedge clk);
         if (cpu_ack === 1'b1) ok = 1'b1;
         else cyc();
      end
      cpu_req = 1'b0;
      chk("xfer_ack", {31'd0, ok}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      logic [16:0] ack_pat;
      int          n_ack;
      checks = 0; errors = 0;
      reset_n = 1'b0; char_tick = 1'b0; display_enable = 1'b0; crtc_addr = '0;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;

      // reset state
      #12;
      chk("rst_ram_addr", ram_addr, 0);
      chk("rst_ram_we", ram_we, 0);
      chk("rst_ack", cpu_ack, 0);
      chk("rst_char", char_byte, 0);
      chk("rst_att", att_byte, 0);
      chk("rst_done_ovr", {fetch_done, overrun}, 0);
      chk("rst_rdata", cpu_rdata, 0);
      reset_n = 1'b1;

      // idle CPU: write 0x5A to 0x0123 then read it back
      cyc();
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0123; cpu_wdata = 8'h5A;
      @(negedge clk);
      chk("wr_grant_we", ram_we, 1);
      chk("wr_grant_addr", ram_addr, 14'h0123);
      chk("wr_grant_wdata", ram_wdata, 8'h5A);
      chk("wr_wait", cpu_wait, 1);
      cyc();
      @(negedge clk);
      chk("wr_ack", cpu_ack, 1);
      chk("wr_ack_wait", cpu_wait, 0);
      chk("wr_no_b2b", ram_we, 0);
      chk("wr_rdata_held", cpu_rdata, 0);
      cyc();
      cpu_we = 1'b0;
      @(negedge clk);
      chk("rd_grant_addr", ram_addr, 14'h0123);
      chk("rd_grant_we", ram_we, 0);
      chk("rd_no_ack", cpu_ack, 0);
      cyc();
      @(negedge clk);
      chk("rd_ack", cpu_ack, 1);
      chk("rd_raw_data", cpu_rdata, 8'h5A);
      cpu_req = 1'b0;
      cyc();
      @(negedge clk);
      chk("rd_ack_single", cpu_ack, 0);
      chk("rd_rdata_hold", cpu_rdata, 8'h5A);

      // preload VRAM through the CPU port
      cpu_xfer(1'b1, 14'h0040, 8'h41);
      cpu_xfer(1'b1, 14'h0041, 8'h1E);
      cpu_xfer(1'b1, 14'h0200, 8'h77);
      cpu_xfer(1'b1, 14'h0300, 8'h33);
      cpu_xfer(1'b1, 14'h0080, 8'h11);
      cpu_xfer(1'b1, 14'h0081, 8'h22);
      cpu_xfer(1'b1, 14'h00C0, 8'h55);
      cpu_xfer(1'b1, 14'h00C1, 8'h66);

      // display fetch with a pending CPU read
      cyc();
      char_tick = 1'b1; display_enable = 1'b1; crtc_addr = 13'h0020;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0200;
      @(negedge clk);
      chk("df_t0_we", ram_we, 0);
      chk("df_t0_addr", ram_addr, 0);
      chk("df_t0_wait", cpu_wait, 1);
      cyc();
      char_tick = 1'b0;
      @(negedge clk);
      chk("df_t1_addr", ram_addr, 14'h0040);
      chk("df_t1_we", ram_we, 0);
      cyc();
      @(negedge clk);
      chk("df_t2_addr", ram_addr, 14'h0041);
      chk("df_t2_wait", cpu_wait, 1);
      cyc();
      @(negedge clk);
      chk("df_t3_cpu_addr", ram_addr, 14'h0200);
      chk("df_t3_char", char_byte, 8'h41);
      chk("df_t3_done", fetch_done, 0);
      cyc();
      @(negedge clk);
      chk("df_t4_att", att_byte, 8'h1E);
      chk("df_t4_done", fetch_done, 1);
      chk("df_t4_ack", cpu_ack, 1);
      chk("df_t4_rdata", cpu_rdata, 8'h77);
      cpu_req = 1'b0;
      cyc();
      @(negedge clk);
      chk("df_t5_done", fetch_done, 0);

      // contention: CPU request held across ticks every 8 clocks
      ack_pat = 17'b1_0101_0001_0101_0000;
      n_ack = 0;
      for (int i = 0; i <= 16; i++) begin
         cyc();
         char_tick = (i % 8 == 0);
         if (i == 0) begin
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0300;
         end
         @(negedge clk);
         chk($sformatf("ct_ack_%0d", i), cpu_ack, ack_pat[i]);
         chk($sformatf("ct_wait_%0d", i), cpu_wait, !ack_pat[i]);
         chk($sformatf("ct_we_%0d", i), ram_we, 0);
         if (i % 8 == 1) chk($sformatf("ct_fc_%0d", i), ram_addr, 14'h0040);
         if (i % 8 == 2) chk($sformatf("ct_fa_%0d", i), ram_addr, 14'h0041);
         if (ack_pat[i]) chk($sformatf("ct_rdata_%0d", i), cpu_rdata, 8'h33);
         if (cpu_ack === 1'b1 && i > 0) n_ack++;
         if (i == 8) begin
            chk("ct_acks_p0", n_ack, 3);
            n_ack = 0;
         end
      end
      chk("ct_acks_p1", n_ack, 3);
      cpu_req = 1'b0;
      cyc();
      char_tick = 1'b0;
      for (int i = 0; i < 4; i++) cyc();

      // blanked period: change VRAM under the cell, tick with display off
      cpu_xfer(1'b1, 14'h0040, 8'h99);
      cpu_xfer(1'b1, 14'h0041, 8'h88);
      cyc();
      char_tick = 1'b1; display_enable = 1'b0; crtc_addr = 13'h0020;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0500; cpu_wdata = 8'hC3;
      @(negedge clk);
      chk("bl_t0_we", ram_we, 0);
      chk("bl_t0_addr", ram_addr, 0);
      cyc();
      char_tick = 1'b0;
      @(negedge clk);
      chk("bl_t1_we", ram_we, 1);
      chk("bl_t1_addr", ram_addr, 14'h0500);
      cyc();
      @(negedge clk);
      chk("bl_t2_ack", cpu_ack, 1);
      chk("bl_t2_addr", ram_addr, 0);
      cpu_req = 1'b0;
      cyc();
      cyc();
      @(negedge clk);
      chk("bl_char", char_byte, 8'h41);
      chk("bl_att", att_byte, 8'h1E);
      chk("bl_done", fetch_done, 0);

      // overrun: second tick two clocks after the first
      cyc();
      char_tick = 1'b1; display_enable = 1'b1; crtc_addr = 13'h0040;
      @(negedge clk);
      chk("ov_t0_ovr", overrun, 0);
      cyc();
      char_tick = 1'b0;
      @(negedge clk);
      chk("ov_t1_addr", ram_addr, 14'h0080);
      cyc();
      char_tick = 1'b1; crtc_addr = 13'h0060;
      @(negedge clk);
      chk("ov_t2_addr", ram_addr, 14'h0081);
      chk("ov_t2_ovr", overrun, 0);
      cyc();
      char_tick = 1'b0;
      @(negedge clk);
      chk("ov_t3_addr", ram_addr, 14'h00C0);
      chk("ov_t3_ovr", overrun, 1);
      chk("ov_t3_char", char_byte, 8'h11);
      chk("ov_t3_done", fetch_done, 0);
      cyc();
      @(negedge clk);
      chk("ov_t4_addr", ram_addr, 14'h00C1);
      chk("ov_t4_ovr", overrun, 0);
      chk("ov_t4_att", att_byte, 8'h22);
      chk("ov_t4_done", fetch_done, 0);
      cyc();
      @(negedge clk);
      chk("ov_t5_char", char_byte, 8'h55);
      chk("ov_t5_done", fetch_done, 0);
      cyc();
      @(negedge clk);
      chk("ov_t6_att", att_byte, 8'h66);
      chk("ov_t6_done", fetch_done, 1);
      cyc();
      @(negedge clk);
      chk("ov_t7_done", fetch_done, 0);

      // reset in the middle of a CPU read grant
      cyc();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0123;
      @(negedge clk);
      chk("mr_grant_addr", ram_addr, 14'h0123);
      reset_n = 1'b0;
      #1;
      chk("mr_addr", ram_addr, 0);
      chk("mr_we", ram_we, 0);
      chk("mr_ack", cpu_ack, 0);
      chk("mr_char", char_byte, 0);
      chk("mr_att", att_byte, 0);
      chk("mr_rdata", cpu_rdata, 0);
      cyc();
      @(negedge clk);
      reset_n = 1'b1;
      cpu_req = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         @(negedge clk);
         chk($sformatf("mr_post_ack_%0d", i), cpu_ack, 0);
         chk($sformatf("mr_post_done_%0d", i), fetch_done, 0);
      end
      cpu_xfer(1'b0, 14'h0123, 8'h00);
      chk("mr_reissue_rdata", cpu_rdata, 8'h5A);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
